// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default byte width and the round-robin wrap helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } arbState_t;

    localparam int DEFAULT_DATA_BITS = 8;

    // Index following idx in a ring of n entries.
    function automatic int unsigned nextIndex(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first asserted request at or after
// Start, scanning upward and wrapping, returned as index and one-hot.
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         Req,
    input  logic [$clog2(NUM_REQ)-1:0] Start,
    output logic                       Found,
    output logic [$clog2(NUM_REQ)-1:0] Index,
    output logic [NUM_REQ-1:0]         OneHot
);

    localparam int IW = $clog2(NUM_REQ);

    always_comb begin
        Found = 1'b0;
        Index = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!Found && Req[(32'(Start) + k) % NUM_REQ]) begin
                Found = 1'b1;
                Index = IW'((32'(Start) + k) % NUM_REQ);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign OneHot[gi] = Found && (Index == IW'(gi));
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_REQ byte requesters onto one UART transmitter with bounded
// bursts per requester, round-robin rotation and a TxDone watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_BITS      = DEFAULT_DATA_BITS,
    parameter int MAX_BURST      = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                         Clock,
    input  logic                         ResetN,
    input  logic [NUM_REQ-1:0]           Req,
    input  logic [NUM_REQ*DATA_BITS-1:0] ReqData,
    output logic [NUM_REQ-1:0]           Ack,
    output logic                         TxStart,
    output logic [DATA_BITS-1:0]         TxData,
    input  logic                         TxDone,
    output logic                         Busy,
    output logic [$clog2(NUM_REQ)-1:0]   GrantId,
    output logic                         Timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    arbState_t               stateReg;
    logic [BW-1:0]           burstCountReg;
    logic [TW-1:0]           timerReg;
    // Set after reset and after a timeout so the next grant must rotate.
    logic                    forceRotateReg;

    logic [DATA_BITS-1:0]    reqBytes [NUM_REQ];
    logic [IW-1:0]           startIdx;
    logic                    pickFound;
    logic [IW-1:0]           pickIndex;
    logic [NUM_REQ-1:0]      pickOneHot;
    logic                    keepNext;
    logic                    grantValid;
    logic [IW-1:0]           winnerNext;
    logic [NUM_REQ-1:0]      ackNext;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
        assign reqBytes[gi] = ReqData[gi*DATA_BITS +: DATA_BITS];
    end

    assign startIdx = IW'(nextIndex(32'(GrantId), NUM_REQ));

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) uPicker (
        .Req    (Req),
        .Start  (startIdx),
        .Found  (pickFound),
        .Index  (pickIndex),
        .OneHot (pickOneHot)
    );

    assign keepNext   = !forceRotateReg && Req[GrantId]
                        && (32'(burstCountReg) < 32'(MAX_BURST - 1));
    assign grantValid = keepNext || pickFound;
    assign winnerNext = keepNext ? GrantId : pickIndex;
    assign ackNext    = keepNext ? (NUM_REQ'(1) << GrantId) : pickOneHot;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            stateReg       <= IDLE;
            Ack            <= '0;
            TxStart        <= 1'b0;
            TxData         <= '0;
            GrantId        <= IW'(NUM_REQ - 1);
            Busy           <= 1'b0;
            Timeout        <= 1'b0;
            burstCountReg  <= '0;
            timerReg       <= '0;
            forceRotateReg <= 1'b1;
        end else begin
            Ack     <= '0;
            TxStart <= 1'b0;
            Timeout <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (grantValid) begin
                        stateReg       <= SEND;
                        Busy           <= 1'b1;
                        TxStart        <= 1'b1;
                        Ack            <= ackNext;
                        GrantId        <= winnerNext;
                        TxData         <= reqBytes[winnerNext];
                        burstCountReg  <= keepNext ? burstCountReg + 1'b1 : '0;
                        forceRotateReg <= 1'b0;
                    end
                end
                SEND: begin
                    stateReg <= WAIT;
                    timerReg <= '0;
                end
                WAIT: begin
                    // TxDone takes priority over a coincident expiry.
                    if (TxDone) begin
                        stateReg <= IDLE;
                        Busy     <= 1'b0;
                    end else if (timerReg == TW'(TIMEOUT_CYCLES - 1)) begin
                        stateReg       <= IDLE;
                        Busy           <= 1'b0;
                        Timeout        <= 1'b1;
                        burstCountReg  <= '0;
                        forceRotateReg <= 1'b1;
                    end else begin
                        timerReg <= timerReg + 1'b1;
                    end
                end
                default: begin
                    stateReg <= IDLE;
                    Busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
